// File: rtl/counter_seq_checker.sv
// counter_seq_checker: passive cycle-accurate checker for a loadable up-counter.
// Predicts each next count from the sampled controls and the observed count, and records mismatches.
`default_nettype none

module counter_seq_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8,
  parameter int CHK_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_err,
  input  logic             obs_rst,
  input  logic             obs_load,
  input  logic [WIDTH-1:0] obs_load_val,
  input  logic [WIDTH-1:0] obs_count,
  output logic [1:0]       state,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CHK_W-1:0] chk_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    CHECK = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] nxt;
  logic             do_cmp;
  logic             mismatch;
  logic             exp_upd;
  logic [ERR_W-1:0] err_base;
  logic [ERR_W-1:0] err_next;
  logic [CHK_W-1:0] chk_base;
  logic [CHK_W-1:0] chk_next;
  logic             sticky_base;
  logic             capture;

  // Prediction is built from the observed count so one bad sample cannot cascade.
  always_comb begin
    nxt = obs_count + WIDTH'(1);
    if (obs_rst) begin
      nxt = '0;
    end else if (obs_load) begin
      nxt = obs_load_val;
    end
  end

  always_comb begin
    state_d = state_q;
    exp_upd = 1'b0;
    do_cmp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = SYNC;
      end
      SYNC: begin
        exp_upd = 1'b1;
        state_d = en ? CHECK : IDLE;
      end
      CHECK: begin
        exp_upd = 1'b1;
        do_cmp  = en;
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mismatch = do_cmp && (obs_count != exp_q);

  // A same-edge clear is applied before the new result is accumulated.
  always_comb begin
    err_base    = clr_err ? '0 : err_cnt;
    chk_base    = clr_err ? '0 : chk_cnt;
    sticky_base = clr_err ? 1'b0 : err_sticky;
    err_next    = err_base;
    chk_next    = chk_base;
    if (mismatch && (err_base != '1)) err_next = err_base + ERR_W'(1);
    if (do_cmp && (chk_base != '1))   chk_next = chk_base + CHK_W'(1);
    capture     = mismatch && !sticky_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      chk_cnt    <= '0;
      first_exp  <= '0;
      first_got  <= '0;
    end else begin
      state_q    <= state_d;
      if (exp_upd) exp_q <= nxt;
      err_pulse  <= mismatch;
      err_sticky <= sticky_base | mismatch;
      err_cnt    <= err_next;
      chk_cnt    <= chk_next;
      if (capture) begin
        first_exp <= exp_q;
        first_got <= obs_count;
      end else if (clr_err) begin
        first_exp <= '0;
        first_got <= '0;
      end
    end
  end

  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_seq_checker.sv
// tb_counter_seq_checker: randomized scenario bench with a behavioural counter/checker model.
`default_nettype none

module tb_counter_seq_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr_err;
  logic        obs_rst;
  logic        obs_load;
  logic [3:0]  obs_load_val;
  logic [3:0]  obs_count;
  logic [1:0]  state;
  logic        err_pulse;
  logic        err_sticky;
  logic [7:0]  err_cnt;
  logic [15:0] chk_cnt;
  logic [3:0]  first_exp;
  logic [3:0]  first_got;

  int total = 0;
  int bad   = 0;

  // Model: number of consecutive enabled edges since the last disable/reset,
  // value promised by the previous edge, and error bookkeeping.
  int         m_run;
  logic [3:0] m_pred;
  logic       m_pulse;
  logic       m_sticky;
  int         m_err;
  int         m_chk;
  logic [3:0] m_fe;
  logic [3:0] m_fg;

  counter_seq_checker #(.WIDTH(4), .ERR_W(8), .CHK_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err),
    .obs_rst(obs_rst), .obs_load(obs_load), .obs_load_val(obs_load_val),
    .obs_count(obs_count), .state(state), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .chk_cnt(chk_cnt),
    .first_exp(first_exp), .first_got(first_got)
  );

  always #5 clk = ~clk;

  wire [35:0] dut_all = {state, err_pulse, err_sticky, err_cnt, chk_cnt, first_exp, first_got};

  function automatic logic [35:0] model_all();
    logic [1:0] st;
    st = (m_run == 0) ? 2'b00 : (m_run == 1) ? 2'b01 : 2'b10;
    return {st, m_pulse, m_sticky, 8'(m_err), 16'(m_chk), m_fe, m_fg};
  endfunction

  task automatic model_reset();
    m_run = 0; m_pred = 4'd0; m_pulse = 1'b0; m_sticky = 1'b0;
    m_err = 0; m_chk = 0; m_fe = 4'd0; m_fg = 4'd0;
  endtask

  // Advances one clock: updates the model from the inputs sampled at this edge,
  // then plays the observed counter forward from whatever it showed.
  task automatic tick();
    logic       cmp;
    logic       mis;
    logic [3:0] nx;
    cmp = en && (m_run >= 2);
    mis = cmp && (obs_count !== m_pred);
    if (clr_err) begin
      m_sticky = 1'b0; m_err = 0; m_chk = 0; m_fe = 4'd0; m_fg = 4'd0;
    end
    if (cmp && m_chk < 65535) m_chk++;
    if (mis) begin
      if (!m_sticky) begin
        m_fe = m_pred;
        m_fg = obs_count;
      end
      m_sticky = 1'b1;
      if (m_err < 255) m_err++;
    end
    m_pulse = mis;
    nx = obs_rst ? 4'd0 : (obs_load ? obs_load_val : 4'(obs_count + 4'd1));
    m_pred = nx;
    m_run = en ? ((m_run < 2) ? m_run + 1 : 2) : 0;
    @(posedge clk);
    #1;
    obs_count = nx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; clr_err = 1'b0; obs_rst = 1'b0;
    obs_load = 1'b0; obs_load_val = 4'd0; obs_count = 4'd0;
    model_reset();
    #3;
    total++;
    if (dut_all !== 36'h0) begin
      bad++; $display("FAIL reset_values got=%h exp=%h", dut_all, 36'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (dut_all !== model_all()) begin
      bad++; $display("FAIL idle_hold got=%h exp=%h", dut_all, model_all());
    end
  endtask

  task automatic test_sync_count();
    int n;
    en = 1'b1;
    tick();
    total++;
    if (state !== 2'b01) begin bad++; $display("FAIL state_sync got=%b exp=01", state); end
    tick();
    total++;
    if (state !== 2'b10) begin bad++; $display("FAIL state_check got=%b exp=10", state); end
    n = 10 + int'($urandom % 10);
    for (int i = 0; i < n; i++) begin
      tick();
      total++;
      if (dut_all !== model_all() || err_pulse !== 1'b0) begin
        bad++; $display("FAIL free_run cyc=%0d got=%h exp=%h", i, dut_all, model_all());
      end
    end
    total++;
    if (chk_cnt !== 16'(n) || err_sticky !== 1'b0) begin
      bad++; $display("FAIL free_run_counts chk=%0d sticky=%b exp chk=%0d sticky=0", chk_cnt, err_sticky, n);
    end
  endtask

  task automatic test_load();
    logic [3:0] vals [3];
    vals[0] = 4'd5; vals[1] = 4'd10; vals[2] = 4'($urandom);
    for (int v = 0; v < 3; v++) begin
      obs_load = 1'b1; obs_load_val = vals[v];
      tick();
      obs_load = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        total++;
        if (dut_all !== model_all() || err_cnt !== 8'd0) begin
          bad++; $display("FAIL load_%0d step=%0d got=%h exp=%h", vals[v], k, dut_all, model_all());
        end
      end
    end
  endtask

  task automatic test_wrap();
    obs_load = 1'b1; obs_load_val = 4'd14;
    tick();
    obs_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total++;
      if (err_pulse !== 1'b0 || err_cnt !== 8'd0 || dut_all !== model_all()) begin
        bad++; $display("FAIL wrap step=%0d got=%h exp=%h", k, dut_all, model_all());
      end
    end
  endtask

  task automatic test_fault();
    obs_load = 1'b1; obs_load_val = 4'd6;
    tick();
    obs_load = 1'b0;
    tick();
    obs_count = 4'd9;
    tick();
    total++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || first_exp !== 4'd7 || first_got !== 4'd9) begin
      bad++; $display("FAIL fault_capture pulse=%b cnt=%0d fe=%0d fg=%0d exp 1/1/7/9",
                      err_pulse, err_cnt, first_exp, first_got);
    end
    tick();
    total++;
    if (err_pulse !== 1'b0 || err_cnt !== 8'd1 || err_sticky !== 1'b1) begin
      bad++; $display("FAIL fault_resync pulse=%b cnt=%0d sticky=%b exp 0/1/1", err_pulse, err_cnt, err_sticky);
    end
  endtask

  task automatic test_reset_priority();
    int n;
    obs_rst = 1'b1; obs_load = 1'b1; obs_load_val = 4'd12;
    tick();
    obs_rst = 1'b0; obs_load = 1'b0;
    tick();
    total++;
    if (err_pulse !== 1'b0 || err_cnt !== 8'd1) begin
      bad++; $display("FAIL rst_over_load pulse=%b cnt=%0d exp 0/1", err_pulse, err_cnt);
    end
    tick();
    tick();
    obs_count = 4'd4;
    tick();
    total++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd2 || first_exp !== 4'd7 || first_got !== 4'd9) begin
      bad++; $display("FAIL second_fault pulse=%b cnt=%0d fe=%0d fg=%0d exp 1/2/7/9",
                      err_pulse, err_cnt, first_exp, first_got);
    end
    obs_rst = 1'b1;
    n = 5 + int'($urandom % 6);
    for (int i = 0; i < n; i++) begin
      if (i == 3) obs_count = 4'd1 + 4'($urandom % 15);
      tick();
      total++;
      if (dut_all !== model_all()) begin
        bad++; $display("FAIL rst_hold cyc=%0d got=%h exp=%h", i, dut_all, model_all());
      end
    end
    obs_rst = 1'b0;
  endtask

  task automatic test_clear();
    logic [3:0] e;
    logic [3:0] g;
    e = m_pred;
    g = 4'(m_pred + 4'd5);
    obs_count = g;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (err_cnt !== 8'd1 || chk_cnt !== 16'd1 || err_sticky !== 1'b1 ||
        first_exp !== e || first_got !== g || state !== 2'b10) begin
      bad++; $display("FAIL clear_with_error cnt=%0d chk=%0d sticky=%b fe=%0d fg=%0d st=%b exp 1/1/1/%0d/%0d/10",
                      err_cnt, chk_cnt, err_sticky, first_exp, first_got, state, e, g);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (dut_all !== model_all() || err_sticky !== 1'b0 || chk_cnt !== 16'd1) begin
      bad++; $display("FAIL clear_clean got=%h exp=%h", dut_all, model_all());
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      obs_count = 4'(m_pred + 4'd3);
      tick();
      total++;
      if (dut_all !== model_all()) begin
        bad++; $display("FAIL saturate cyc=%0d got=%h exp=%h", i, dut_all, model_all());
      end
    end
    total++;
    if (err_cnt !== 8'hFF || err_pulse !== 1'b1) begin
      bad++; $display("FAIL err_cnt_sat got=%0d pulse=%b exp 255/1", err_cnt, err_pulse);
    end
    tick();
    total++;
    if (err_cnt !== 8'hFF || err_pulse !== 1'b0) begin
      bad++; $display("FAIL err_cnt_hold got=%0d pulse=%b exp 255/0", err_cnt, err_pulse);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      en           = ($urandom % 16) != 0;
      clr_err      = ($urandom % 25) == 0;
      obs_rst      = ($urandom % 16) == 0;
      obs_load     = ($urandom % 6) == 0;
      obs_load_val = 4'($urandom);
      if (($urandom % 8) == 0) obs_count = 4'($urandom);
      tick();
      total++;
      if (dut_all !== model_all()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_all, model_all());
      end
    end
    clr_err = 1'b0; obs_rst = 1'b0; obs_load = 1'b0;
  endtask

  task automatic test_midrun_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_all !== 36'h0) begin
      bad++; $display("FAIL midrun_reset got=%h exp=%h", dut_all, 36'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    obs_count = 4'd0;
    tick();
    total++;
    if (state !== 2'b01 || chk_cnt !== 16'd0) begin
      bad++; $display("FAIL resume_sync st=%b chk=%0d exp 01/0", state, chk_cnt);
    end
    tick();
    total++;
    if (state !== 2'b10 || chk_cnt !== 16'd0) begin
      bad++; $display("FAIL resume_check st=%b chk=%0d exp 10/0", state, chk_cnt);
    end
    tick();
    total++;
    if (chk_cnt !== 16'd1 || dut_all !== model_all()) begin
      bad++; $display("FAIL resume_first_cmp got=%h exp=%h", dut_all, model_all());
    end
  endtask

  initial begin
    test_reset();
    test_sync_count();
    test_load();
    test_wrap();
    test_fault();
    test_reset_priority();
    test_clear();
    test_saturation();
    test_random();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
